turn_cmd_encoder: RTL and testbench

- Consumer end of the debounced-button interface.
- Takes the two clean button levels (left/right turn) and converts them into discrete turn commands.
- Commands are buffered in a small FIFO and handed to the snake game-tick logic over a valid/ready handshake.
- Optional hold-to-repeat generates repeated commands while a button stays pressed.

---
 rtl/turn_cmd_encoder_pkg.sv | 23 ++
 rtl/turn_cmd_encoder_if.sv | 39 +++
 rtl/turn_cmd_encoder_btn_repeat_fsm.sv | 133 +++++++++++++
 rtl/turn_cmd_encoder.sv | 136 +++++++++++++
 tb/tb_turn_cmd_encoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/turn_cmd_encoder_pkg.sv
// ---------------------------------------------------------------------------
// snake_input_pkg
// Shared constants and types for the snake button-input path.
//   DIR_LEFT / DIR_RIGHT : encoding of a turn command on cmd_dir
//   btn_state_t          : per-button FSM state encoding
//   max2()               : constant helper used to size the repeat counter
// ---------------------------------------------------------------------------
package snake_input_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/turn_cmd_encoder_if.sv
// ---------------------------------------------------------------------------
// turn_cmd_encoder_if
// Bundles the button levels and the command valid/ready handshake.
//   btn_left, btn_right : debounced levels, 1 = pressed
//   cmd_valid           : FIFO head holds a command
//   cmd_dir             : head command, 0 = left, 1 = right
//   cmd_ready           : consumer accepts the head this cycle
//   cmd_drop            : one-cycle pulse when an event is discarded
// modport slave  : the encoder side
// modport master : the side driving buttons and consuming commands
// ---------------------------------------------------------------------------
interface turn_cmd_encoder_if;

  logic btn_left;
  logic btn_right;
  logic cmd_valid;
  logic cmd_dir;
  logic cmd_ready;
  logic cmd_drop;

  modport master (
    output btn_left,
    output btn_right,
    output cmd_ready,
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_drop
  );

  modport slave (
    input  btn_left,
    input  btn_right,
    input  cmd_ready,
    output cmd_valid,
    output cmd_dir,
    output cmd_drop
  );

endinterface

// File: rtl/turn_cmd_encoder_btn_repeat_fsm.sv
// ---------------------------------------------------------------------------
// btn_repeat_fsm
// Per-button press detector with optional hold-to-repeat.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   i_btn   : debounced button level
//   o_event : combinational event pulse, consumed at the next clock edge
// Build option: TURN_AUTO_REPEAT_EN enables the HOLD/REPEAT counter. When it
// is not defined, a press yields exactly one event and the FSM waits in HOLD
// until release; no counter is built.
// ---------------------------------------------------------------------------
module btn_repeat_fsm
  import snake_input_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_event
);

  if ((HOLD_CYCLES < 2) || (REPEAT_CYCLES < 2)) begin : g_bad_cfg
    $error("btn_repeat_fsm: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  // Previous level resets to 1 so a button held through reset is not seen
  // as a fresh press.
  logic       r_prev;
  logic       w_press;
  btn_state_t r_state;
  btn_state_t w_state_next;

  assign w_press = i_btn & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_btn;
    end
  end

`ifdef TURN_AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_event      = 1'b0;
    if (!i_btn) begin
      // Release wins in every state.
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press) begin
            o_event      = 1'b1;
            w_state_next = HOLD;
            w_cnt_next   = '0;
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            o_event      = 1'b1;
            w_state_next = REPEAT;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (r_cnt == REPEAT_LAST) begin
            o_event    = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_event      = 1'b0;
    if (!i_btn) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press) begin
            o_event      = 1'b1;
            w_state_next = HOLD;
          end
        end
        HOLD:    w_state_next = HOLD;
        default: w_state_next = IDLE;
      endcase
    end
  end
`endif

endmodule

// File: rtl/turn_cmd_encoder.sv
// ---------------------------------------------------------------------------
// turn_cmd_encoder
// Converts the two debounced button levels into left/right turn commands,
// buffers them in a small FIFO and presents them over valid/ready.
//   clk : system clock, all logic on posedge
//   rst : asynchronous active-high reset; release is expected to be
//         synchronous to clk
//   bus : turn_cmd_encoder_if.slave
//         btn_left/btn_right in, cmd_ready in,
//         cmd_valid/cmd_dir/cmd_drop out (all registered)
// Build option: TURN_AUTO_REPEAT_EN (hold-to-repeat inside btn_repeat_fsm).
// ---------------------------------------------------------------------------
module turn_cmd_encoder
  import snake_input_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  turn_cmd_encoder_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("turn_cmd_encoder: FIFO_DEPTH must be a power of two >= 2");
  end

  // Index 0 = left, 1 = right, which matches the DIR_* encoding.
  logic [1:0] w_btn;
  logic [1:0] w_event;

  assign w_btn = {bus.btn_right, bus.btn_left};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_repeat_fsm #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_btn[gi]),
      .o_event (w_event[gi])
    );
  end

  // FIFO state
  logic          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_valid;
  logic          r_dir;
  logic          r_drop;

  logic          w_push_req;
  logic          w_push_dir;
  logic          w_both;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_wr_ptr_next;
  logic [AW-1:0] w_rd_ptr_next;
  logic [AW:0]   w_count_next;
  logic          w_head_next;

  // Arbitration: coincident events from both buttons cancel each other.
  assign w_both     = &w_event;
  assign w_push_req = ^w_event;
  assign w_push_dir = w_event[1] ? DIR_RIGHT : DIR_LEFT;

  assign w_full = (r_count == DEPTH_CNT);
  assign w_pop  = r_valid & bus.cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = w_push_req & (~w_full | w_pop);
  assign w_drop = w_both | (w_push_req & ~w_push);

  assign w_wr_ptr_next = r_wr_ptr + AW'(w_push);
  assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  // Next head: when the head slot is the one being written this cycle the
  // memory does not hold it yet, so forward the pushed direction.
  always_comb begin
    w_head_next = DIR_LEFT;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
        w_head_next = w_push_dir;
      end else begin
        w_head_next = r_mem[w_rd_ptr_next];
      end
    end
  end

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_dir;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_dir    <= DIR_LEFT;
      r_drop   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_dir    <= w_head_next;
      r_drop   <= w_drop;
    end
  end

  assign bus.cmd_valid = r_valid;
  assign bus.cmd_dir   = r_dir;
  assign bus.cmd_drop  = r_drop;

endmodule

// File: tb/tb_turn_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_turn_cmd_encoder
// Directed bench for turn_cmd_encoder with HOLD_CYCLES=4, REPEAT_CYCLES=2,
// FIFO_DEPTH=2. Expected repeat counts follow TURN_AUTO_REPEAT_EN.
// Inputs change 1 time unit after a rising edge; a negedge monitor counts
// handshakes and drop pulses.
// ---------------------------------------------------------------------------
module tb_turn_cmd_encoder;

`ifdef TURN_AUTO_REPEAT_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  turn_cmd_encoder_if bus ();

  turn_cmd_encoder #(
    .HOLD_CYCLES   (4),
    .REPEAT_CYCLES (2),
    .FIFO_DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int hs_count   = 0;
  int hs_right   = 0;
  int drop_count = 0;
  bit dq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        hs_count++;
        if (bus.cmd_dir) hs_right++;
        dq.push_back(bus.cmd_dir);
      end
      if (bus.cmd_drop) drop_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_left();
    bus.btn_left = 1'b1;
    tick(1);
    bus.btn_left = 1'b0;
    tick(2);
  endtask

  task automatic pulse_right();
    bus.btn_right = 1'b1;
    tick(1);
    bus.btn_right = 1'b0;
    tick(2);
  endtask

  int b_hs, b_hr, b_dr;
  int n;

  initial begin
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b0;
    bus.cmd_ready = 1'b1;

    // Reset with left held; no event after release until a fresh press.
    tick(3);
    check("rst_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_dir",   32'(bus.cmd_dir),   32'd0);
    check("rst_drop",  32'(bus.cmd_drop),  32'd0);
    rst = 1'b0;
    tick(10);
    check("held_thru_rst_hs",   32'(hs_count),   32'd0);
    check("held_thru_rst_drop", 32'(drop_count), 32'd0);
    bus.btn_left = 1'b0;
    tick(2);
    pulse_left();
    tick(1);
    check("repress_hs",    32'(hs_count), 32'd1);
    check("repress_right", 32'(hs_right), 32'd0);

    // Single-cycle left pulse: valid for exactly one cycle.
    b_hs = hs_count;
    bus.btn_left = 1'b1;
    tick(1);
    check("pulse_valid", 32'(bus.cmd_valid), 32'd1);
    check("pulse_dir",   32'(bus.cmd_dir),   32'd0);
    bus.btn_left = 1'b0;
    tick(1);
    check("pulse_valid_fall", 32'(bus.cmd_valid), 32'd0);
    tick(2);
    check("pulse_hs", 32'(hs_count - b_hs), 32'd1);

    // Right held for 10 edges: events at +0, +4, +6, +8.
    b_hs = hs_count; b_hr = hs_right; b_dr = drop_count;
    bus.btn_right = 1'b1;
    tick(10);
    bus.btn_right = 1'b0;
    tick(4);
    check("hold_hs",    32'(hs_count - b_hs),   32'(AUTO ? 4 : 1));
    check("hold_right", 32'(hs_right - b_hr),   32'(AUTO ? 4 : 1));
    check("hold_drop",  32'(drop_count - b_dr), 32'd0);
    check("hold_valid", 32'(bus.cmd_valid),     32'd0);
    b_hs = hs_count;
    pulse_right();
    tick(1);
    check("hold_reidle_hs", 32'(hs_count - b_hs), 32'd1);

    // Stall: two commands stored, third dropped, then drained in order.
    bus.cmd_ready = 1'b0;
    b_hs = hs_count; b_dr = drop_count;
    pulse_left();
    pulse_right();
    pulse_left();
    check("full_valid", 32'(bus.cmd_valid),     32'd1);
    check("full_dir",   32'(bus.cmd_dir),       32'd0);
    check("full_drop",  32'(drop_count - b_dr), 32'd1);
    check("full_hs",    32'(hs_count - b_hs),   32'd0);
    bus.cmd_ready = 1'b1;
    tick(1);
    check("drain_valid1", 32'(bus.cmd_valid), 32'd1);
    check("drain_dir1",   32'(bus.cmd_dir),   32'd1);
    tick(1);
    check("drain_valid0", 32'(bus.cmd_valid), 32'd0);
    check("drain_hs", 32'(hs_count - b_hs), 32'd2);
    n = dq.size();
    check("drain_order", {30'd0, dq[n-2], dq[n-1]}, 32'b01);

    // Both pressed together: dropped; left alone then repeats at +4.
    b_hs = hs_count; b_hr = hs_right; b_dr = drop_count;
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b1;
    tick(1);
    check("both_drop",  32'(bus.cmd_drop),  32'd1);
    check("both_valid", 32'(bus.cmd_valid), 32'd0);
    bus.btn_right = 1'b0;
    tick(3);
    check("both_pre_rep_valid", 32'(bus.cmd_valid), 32'd0);
    tick(1);
    check("both_rep_valid", 32'(bus.cmd_valid), 32'(AUTO));
    bus.btn_left = 1'b0;
    tick(3);
    check("both_drop_cnt", 32'(drop_count - b_dr), 32'd1);
    check("both_hs",       32'(hs_count - b_hs),   32'(AUTO));
    check("both_right",    32'(hs_right - b_hr),   32'd0);

    // Full FIFO with pop and push in the same cycle.
    bus.cmd_ready = 1'b0;
    b_hs = hs_count; b_dr = drop_count;
    pulse_left();
    pulse_right();
    check("pp_full_dir", 32'(bus.cmd_dir), 32'd0);
    bus.cmd_ready = 1'b1;
    bus.btn_left  = 1'b1;
    tick(1);
    check("pp_valid", 32'(bus.cmd_valid), 32'd1);
    check("pp_dir",   32'(bus.cmd_dir),   32'd1);
    check("pp_drop",  32'(bus.cmd_drop),  32'd0);
    bus.cmd_ready = 1'b0;
    bus.btn_left  = 1'b0;
    tick(2);
    bus.cmd_ready = 1'b1;
    tick(1);
    check("pp_valid2", 32'(bus.cmd_valid), 32'd1);
    check("pp_dir2",   32'(bus.cmd_dir),   32'd0);
    tick(1);
    check("pp_valid3", 32'(bus.cmd_valid), 32'd0);
    check("pp_hs",     32'(hs_count - b_hs),   32'd3);
    check("pp_drop_cnt", 32'(drop_count - b_dr), 32'd0);
    n = dq.size();
    check("pp_order", {29'd0, dq[n-3], dq[n-2], dq[n-1]}, 32'b010);

    // Left held 20 edges: 1 + 8 repeats with auto-repeat, else 1.
    b_hs = hs_count; b_dr = drop_count;
    bus.btn_left = 1'b1;
    tick(20);
    bus.btn_left = 1'b0;
    tick(4);
    check("long_hs",   32'(hs_count - b_hs),   32'(AUTO ? 9 : 1));
    check("long_drop", 32'(drop_count - b_dr), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
